// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control FSM: opcodes, state encodings and
// datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  typedef enum logic [3:0] {
    StReset  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12
  } state_e;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  // States that wait on mem_ready and are covered by the watchdog.
  function automatic logic is_wait_state(input state_e s);
    return s inside {StFetch, StMemRd, StMemWr};
  endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Watchdog for memory/GPIO wait states; timeout fires on the cycle the count reaches
// MEM_WAIT_MAX-1 while still counting. MEM_WAIT_MAX = 0 disables it.
module mips_mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(MEM_WAIT_MAX == 0 ? 0 : MEM_WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (MEM_WAIT_MAX != 0) && count && (cnt_q == Limit);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath with mem_ready wait states and a watchdog.
// Define MIPS_CTRL_BNE_EN to decode bne (0x05) as an inverted-condition branch.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  logic   bus_err_q, bus_err_d;
  logic   wait_count, timer_clear, timeout;
`ifdef MIPS_CTRL_BNE_EN
  logic   is_bne_q, is_bne_d;
`endif

  assign wait_count  = is_wait_state(state_q) && !mem_ready;
  // Any state change (or a timeout retry of FETCH) counts as a fresh entry.
  assign timer_clear = (state_d != state_q) || timeout;

  mips_mem_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .count   (wait_count),
    .timeout (timeout)
  );

  always_comb begin
    state_d    = state_q;
    bus_err_d  = bus_err_q;
`ifdef MIPS_CTRL_BNE_EN
    is_bne_d   = is_bne_q;
`endif
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBReg;
    alu_op     = AluAdd;
    pc_src     = PcAlu;
    illegal_op = 1'b0;

    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        alu_src_b = SrcBImmSh;
`ifdef MIPS_CTRL_BNE_EN
        is_bne_d  = (opcode == OpBne);
`endif
        case (opcode)
          OpRtype:    state_d = StExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
`ifdef MIPS_CTRL_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = StFetch;
        end
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = StFetch;
        end
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = AluFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = AluSub;
        pc_src    = PcAluOut;
`ifdef MIPS_CTRL_BNE_EN
        pc_en     = is_bne_q ? ~zero : zero;
`else
        pc_en     = zero;
`endif
        state_d   = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src  = PcJump;
        pc_en   = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StReset;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef MIPS_CTRL_BNE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_bne_q <= 1'b0;
    end else begin
      is_bne_q <= is_bne_d;
    end
  end
`endif

  assign bus_err = bus_err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: per-instruction latency and strobe counts
// are predicted from the instruction class and injected wait cycles.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int unsigned WaitMax = 4;

  logic       clk, rst;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op, bus_err;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;

  int checks;
  int errors;

  typedef enum int {KR, KLw, KSw, KBeq, KBne, KAddi, KJ, KIll} kind_e;

  mips_multicycle_ctrl #(
    .MEM_WAIT_MAX (WaitMax),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .bus_err    (bus_err),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic kind_e kind_of(input logic [5:0] op);
    case (op)
      6'h00:   return KR;
      6'h23:   return KLw;
      6'h2B:   return KSw;
      6'h04:   return KBeq;
`ifdef MIPS_CTRL_BNE_EN
      6'h05:   return KBne;
`endif
      6'h08:   return KAddi;
      6'h02:   return KJ;
      default: return KIll;
    endcase
  endfunction

  // Zero-wait cycle counts from FETCH back to FETCH.
  function automatic int latency(input kind_e k);
    case (k)
      KR, KSw, KAddi: return 4;
      KLw:            return 5;
      KBeq, KBne, KJ: return 3;
      default:        return 2;
    endcase
  endfunction

  // Runs one instruction from FETCH with wf fetch waits and w2 data-access waits, then
  // compares observed strobe activity against counts derived from the instruction class.
  task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int w2,
                           input logic exp_berr);
    kind_e      k;
    bit         mem;
    int         total;
    int         n_mr, n_mw, n_ir, n_rw, n_rd, n_m2r, n_pc, n_ill, n_sub, n_fn;
    logic [1:0] br_src;
    int         exp_pc;
    k = kind_of(op);
    mem = (k == KLw) || (k == KSw);
    total = latency(k) + wf + (mem ? w2 : 0);
    n_mr = 0; n_mw = 0; n_ir = 0; n_rw = 0; n_rd = 0; n_m2r = 0; n_pc = 0; n_ill = 0;
    n_sub = 0; n_fn = 0; br_src = 2'b11;
    opcode = op;
    zero = z;
    for (int c = 0; c < total; c++) begin
      if (c < wf) mem_ready = 1'b0;
      else if (c == wf) mem_ready = 1'b1;
      else if (mem && c >= wf + 3 && c < wf + 3 + w2) mem_ready = 1'b0;
      else if (mem && c == wf + 3 + w2) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 0) check_eq($sformatf("op%02h_start_fetch", op), state_o, StFetch);
      n_mr  += int'(mem_read);
      n_mw  += int'(mem_write);
      n_ir  += int'(ir_write);
      n_rw  += int'(reg_write);
      n_rd  += int'(reg_dst);
      n_m2r += int'(mem_to_reg);
      n_pc  += int'(pc_en);
      n_ill += int'(illegal_op);
      n_sub += int'(alu_op == 2'b01);
      n_fn  += int'(alu_op == 2'b10);
      if (pc_en && !ir_write) br_src = pc_src;
      tick();
    end
    exp_pc = 1 + int'(k == KJ) + int'(k == KBeq && z) + int'(k == KBne && !z);
    check_eq($sformatf("op%02h_mem_read", op), n_mr, 1 + wf + ((k == KLw) ? 1 + w2 : 0));
    check_eq($sformatf("op%02h_mem_write", op), n_mw, (k == KSw) ? 1 + w2 : 0);
    check_eq($sformatf("op%02h_ir_write", op), n_ir, 1);
    check_eq($sformatf("op%02h_reg_write", op), n_rw, int'(k == KR || k == KLw || k == KAddi));
    check_eq($sformatf("op%02h_reg_dst", op), n_rd, int'(k == KR));
    check_eq($sformatf("op%02h_mem_to_reg", op), n_m2r, int'(k == KLw));
    check_eq($sformatf("op%02h_pc_en", op), n_pc, exp_pc);
    check_eq($sformatf("op%02h_illegal", op), n_ill, int'(k == KIll));
    check_eq($sformatf("op%02h_alu_sub", op), n_sub, int'(k == KBeq || k == KBne));
    check_eq($sformatf("op%02h_alu_funct", op), n_fn, int'(k == KR));
    if (exp_pc > 1) check_eq($sformatf("op%02h_pc_src", op), br_src, (k == KJ) ? 2 : 1);
    check_eq($sformatf("op%02h_bus_err", op), bus_err, exp_berr);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] pool [8];
    pool = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3F};
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    state_e rseq [5];
    state_e tseq [8];
    checks = 0;
    errors = 0;
    rst = 1'b1;
    opcode = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b0;

    @(negedge clk);
    check_eq("rst_state", state_o, StReset);
    check_eq("rst_pc_en", pc_en, 0);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_ir_write", ir_write, 0);
    check_eq("rst_reg_write", reg_write, 0);
    check_eq("rst_iord", iord, 0);
    check_eq("rst_alu_src_b", alu_src_b, 0);
    check_eq("rst_pc_src", pc_src, 0);
    check_eq("rst_illegal", illegal_op, 0);
    check_eq("rst_bus_err", bus_err, 0);

    // R-type straight out of reset with mem_ready held high.
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    rseq = '{StReset, StFetch, StDecode, StExec, StAluWb};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("rtype_state%0d", i), state_o, rseq[i]);
      check_eq($sformatf("rtype_reg_write%0d", i), reg_write, i == 4);
      check_eq($sformatf("rtype_reg_dst%0d", i), reg_dst, i == 4);
      tick();
    end

    run_instr(6'h23, 1'b0, 0, 3, 1'b0);
    run_instr(6'h04, 1'b1, 1, 0, 1'b0);
    run_instr(6'h04, 1'b0, 0, 0, 1'b0);
    run_instr(6'h05, 1'b1, 0, 0, 1'b0);
    run_instr(6'h05, 1'b0, 0, 0, 1'b0);
    run_instr(6'h3F, 1'b0, 2, 0, 1'b0);
    run_instr(6'h2B, 1'b0, 3, 3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_instr(pick_op(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0);
    end

    // sw that never completes: watchdog fires after WaitMax MEMWR cycles.
    opcode = 6'h2B;
    tseq = '{StFetch, StDecode, StMemAdr, StMemWr, StMemWr, StMemWr, StMemWr, StFetch};
    for (int c = 0; c < 8; c++) begin
      mem_ready = (c == 0);
      @(negedge clk);
      check_eq($sformatf("tmo_state%0d", c), state_o, tseq[c]);
      check_eq($sformatf("tmo_mem_write%0d", c), mem_write, c >= 3 && c <= 6);
      check_eq($sformatf("tmo_bus_err%0d", c), bus_err, c == 7);
      tick();
    end
    run_instr(6'h00, 1'b0, 0, 0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      run_instr(pick_op(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset during the second MEMWR wait cycle.
    opcode = 6'h2B;
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("rmid_fetch", state_o, StFetch);
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_eq("rmid_wait1_write", mem_write, 1);
    tick();
    check_eq("rmid_wait2_write", mem_write, 1);
    rst = 1'b1;
    #1;
    check_eq("rmid_async_write", mem_write, 0);
    check_eq("rmid_async_state", state_o, StReset);
    check_eq("rmid_async_bus_err", bus_err, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rmid_held_state", state_o, StReset);
    tick();
    run_instr(6'h08, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    check_eq("final_fetch", state_o, StFetch);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
